eth_hdr_fifo_v2: RTL and testbench
==================================

# eth_hdr_fifo_v2

Parametrised Ethernet header FIFO: buffers {dest MAC, src MAC, EtherType, user tag} headers between the header-parse/header-generation stages and the payload datapath. It replaces the single-entry-per-two-cycles header queue and adds the following:
- sustained one-header-per-cycle throughput;
- a configurable depth and a sideband user field;
- occupancy and almost-full status;
- an optional drop-when-full mode with an overflow pulse and a saturating drop counter.

## Interface
Parameters:
- DEPTH, 8, header RAM entries; power of two, ≥2; ADDR_W = $clog2(DEPTH)
- USER_WIDTH, 1, width of sideband tag carried with each header; ≥1
- ALMOST_FULL_THRESH, DEPTH-2, almost_full asserts when count ≥ this value; range 1..DEPTH
- DROP_WHEN_FULL, 0, 0 = backpressure when full; 1 = always ready, discard when full
- DROP_CNT_WIDTH, 16, width of saturating drop counter

Ports (one clock; reset is synchronous and active-low):
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous active-low reset (0 = reset)
- s_eth_hdr_valid  in  1  input header valid
- s_eth_hdr_ready  out  1  input header ready
- s_eth_dest_mac  in  48  destination MAC
- s_eth_src_mac  in  48  source MAC
- s_eth_type  in  16  EtherType
- s_eth_hdr_user  in  USER_WIDTH  sideband tag
- m_eth_hdr_valid  out  1  output header valid
- m_eth_hdr_ready  in  1  output header ready
- m_eth_dest_mac  out  48  destination MAC
- m_eth_src_mac  out  48  source MAC
- m_eth_type  out  16  EtherType
- m_eth_hdr_user  out  USER_WIDTH  sideband tag
- count  out  ADDR_W+1  entries held in RAM; excludes the output register
- almost_full  out  1  count ≥ ALMOST_FULL_THRESH
- overflow  out  1  one-cycle pulse per dropped header (DROP_WHEN_FULL=1 only)
- drop_count  out  DROP_CNT_WIDTH  saturating count of dropped headers

## Operation
- Storage: three RAM arrays (48/48/16 bits) plus a USER_WIDTH array, indexed by wr_ptr/rd_ptr[ADDR_W-1:0].
- Pointers are ADDR_W+1 bits wide. Empty when wr_ptr == rd_ptr. Full when the MSBs differ and the low bits are equal.
- count = wr_ptr − rd_ptr, computed modulo 2^(ADDR_W+1).
- Accept = s_eth_hdr_valid && s_eth_hdr_ready && !full. On accept, the RAM is written at wr_ptr and wr_ptr is incremented.
- s_eth_hdr_ready:
  - DROP_WHEN_FULL=0: ready = !full, decoded from registered pointers; no combinational path from the m_ side.
  - DROP_WHEN_FULL=1: ready is constant 1 outside reset.
- Drop: a valid input while full and DROP_WHEN_FULL=1 is discarded. The header is not written and wr_ptr does not move. overflow pulses high the next cycle. drop_count increments and saturates at all-ones.
- Output stage is a single register:
  - Load condition: (!m_eth_hdr_valid || m_eth_hdr_ready) && !empty. On load, the register takes RAM[rd_ptr], rd_ptr increments, and m_eth_hdr_valid is set.
  - Clear condition: m_eth_hdr_ready && empty clears m_eth_hdr_valid.
- While m_eth_hdr_valid && !m_eth_hdr_ready, the m_* data is held stable.
- Simultaneous write and read in one cycle is legal: both pointers move and count is unchanged.
- Headers emerge in strict arrival order. The user tag always stays paired with its header.

## Timing
- Reset (rst=0 at a clock edge):
  - wr_ptr, rd_ptr ← 0; count = 0.
  - m_eth_hdr_valid, overflow, almost_full ← 0; drop_count ← 0.
  - s_eth_hdr_ready ← 0 during reset, then 1 on the first cycle after reset releases.
  - m_* data registers ← 0.
  - RAM contents are not reset.
- Reset asserted mid-traffic discards every stored and in-flight header. No m_eth_hdr_valid appears until a new accept occurs.
- Latency: a header accepted at edge E is loaded into the output register at edge E+1, so m_eth_hdr_valid is visible after E+1. Minimum latency is 2 cycles, valid to valid.
- Throughput: one header per cycle sustained when m_eth_hdr_ready=1.
- Total buffering: DEPTH+1 headers (DEPTH in RAM plus the output register).
- count and almost_full are registered-pointer derived and reflect edges up to the current cycle.
- Pointer wrap past 2^(ADDR_W+1) is silent; full/empty decoding stays correct across the wrap.

## Structure
- Shared package eth_pkg holds: localparams ETH_MAC_W=48 and ETH_TYPE_W=16, and the header field order used for the packed RAM word {dest, src, type, user}.
- Sub-module: hdr_fifo_ram, a simple dual-port RAM with a registered read and parametrised width/depth. It is instantiated once on the packed 112+USER_WIDTH word. The top level holds pointers, flags, the output register and drop logic.

## Test plan
- Single header: after reset, send dest=0x0A0B0C0D0E0F, src=0x112233445566, type=0x0800, user=1 -> m_valid high 2 cycles later with identical fields; count returns to 0.
- Fill, DEPTH=8, DROP=0, m_ready=0: 9 headers accepted (8 in RAM plus the output register). s_ready drops after the 9th accept; count=8; almost_full=1 from count 6. Release m_ready -> all 9 emerge in order, back-to-back.
- Drop mode, DROP=1, m_ready=0: send 12 headers -> 9 stored; 3 overflow pulses; drop_count=3. The stored headers drain in order, with no dropped headers among them.
- Streaming: 64 headers with continuous valid and ready -> one output per cycle. Pointer wrap is crossed 4 times; sequence and user tags match.
- Random backpressure: m_ready toggled pseudo-randomly over 1000 headers -> scoreboard passes. m_* data is held stable whenever valid && !ready.
- Mid-operation reset: rst=0 for 1 cycle with 5 headers stored -> next cycle m_valid=0, count=0, drop_count=0. A following header emerges alone.

Source files
------------

// File: rtl/eth_pkg.sv
// eth_pkg: shared Ethernet header widths and the packed header layout
// used by the header FIFO storage word.
package eth_pkg;

    localparam int ETH_MAC_W  = 48;
    localparam int ETH_TYPE_W = 16;

    // Header fields, MSB first: dest, src, type. The user tag is appended
    // below the type field when the header is packed into a RAM word.
    typedef struct packed {
        logic [ETH_MAC_W-1:0]  dest;
        logic [ETH_MAC_W-1:0]  src;
        logic [ETH_TYPE_W-1:0] etype;
    } eth_hdr_t;

    localparam int ETH_HDR_W = $bits(eth_hdr_t);

    // Build a header struct from its individual fields.
    function automatic eth_hdr_t eth_hdr_pack(
        input logic [ETH_MAC_W-1:0]  dest,
        input logic [ETH_MAC_W-1:0]  src,
        input logic [ETH_TYPE_W-1:0] etype
    );
        eth_hdr_t h;
        h.dest  = dest;
        h.src   = src;
        h.etype = etype;
        return h;
    endfunction

endpackage

// File: rtl/hdr_fifo_ram.sv
// hdr_fifo_ram: simple dual-port RAM, one write port and one read port
// with a registered read. The read register doubles as the FIFO output
// data register, so it is the only part that is reset.
module hdr_fifo_ram #(
    parameter int WIDTH  = 113,
    parameter int DEPTH  = 8,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WIDTH-1:0]  wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [WIDTH-1:0]  rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Storage array write; contents are deliberately left unreset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Registered read; holds its value when not enabled so the output stays stable.
    always_ff @(posedge clk) begin
        if (!rst) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/eth_hdr_fifo_v2.sv
// eth_hdr_fifo_v2: Ethernet header FIFO with one-header-per-cycle
// throughput, sideband user tag, occupancy/almost-full status and an
// optional drop-when-full mode with overflow pulse and drop counter.
module eth_hdr_fifo_v2
    import eth_pkg::*;
#(
    parameter int DEPTH              = 8,
    parameter int USER_WIDTH         = 1,
    parameter int ALMOST_FULL_THRESH = DEPTH - 2,
    parameter int DROP_WHEN_FULL     = 0,
    parameter int DROP_CNT_WIDTH     = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      s_eth_hdr_valid,
    output logic                      s_eth_hdr_ready,
    input  logic [ETH_MAC_W-1:0]      s_eth_dest_mac,
    input  logic [ETH_MAC_W-1:0]      s_eth_src_mac,
    input  logic [ETH_TYPE_W-1:0]     s_eth_type,
    input  logic [USER_WIDTH-1:0]     s_eth_hdr_user,
    output logic                      m_eth_hdr_valid,
    input  logic                      m_eth_hdr_ready,
    output logic [ETH_MAC_W-1:0]      m_eth_dest_mac,
    output logic [ETH_MAC_W-1:0]      m_eth_src_mac,
    output logic [ETH_TYPE_W-1:0]     m_eth_type,
    output logic [USER_WIDTH-1:0]     m_eth_hdr_user,
    output logic [$clog2(DEPTH):0]    count,
    output logic                      almost_full,
    output logic                      overflow,
    output logic [DROP_CNT_WIDTH-1:0] drop_count
);

    localparam int ADDR_W = $clog2(DEPTH);
    localparam int WORD_W = ETH_HDR_W + USER_WIDTH;
    localparam bit DROP_MODE = (DROP_WHEN_FULL != 0);
    localparam int unsigned AF_INT = ALMOST_FULL_THRESH;
    localparam logic [ADDR_W:0] AF_THRESH = AF_INT[ADDR_W:0];
    localparam logic [ADDR_W:0] PTR_ONE = 1;
    localparam logic [DROP_CNT_WIDTH-1:0] CNT_ONE = 1;

    logic [ADDR_W:0] wr_ptr;
    logic [ADDR_W:0] rd_ptr;
    logic            full;
    logic            empty;
    logic            accept;
    logic            drop;
    logic            load;
    eth_hdr_t        wr_hdr;
    eth_hdr_t        rd_hdr;
    logic [WORD_W-1:0] wr_word;
    logic [WORD_W-1:0] rd_word;

    // The extra pointer MSB distinguishes a full RAM from an empty one at equal low bits.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]) &&
                   (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]);
    assign count       = wr_ptr - rd_ptr;
    assign almost_full = (count >= AF_THRESH);

    // Ready is held low while reset is applied; in drop mode it never backpressures.
    assign s_eth_hdr_ready = rst && (DROP_MODE || !full);
    assign accept = s_eth_hdr_valid && s_eth_hdr_ready && !full;
    assign drop   = DROP_MODE && s_eth_hdr_valid && full;

    // Refill the output register whenever it is empty or being consumed.
    assign load = (!m_eth_hdr_valid || m_eth_hdr_ready) && !empty;

    assign wr_hdr  = eth_hdr_pack(s_eth_dest_mac, s_eth_src_mac, s_eth_type);
    assign wr_word = {wr_hdr, s_eth_hdr_user};
    assign {rd_hdr, m_eth_hdr_user} = rd_word;
    assign m_eth_dest_mac = rd_hdr.dest;
    assign m_eth_src_mac  = rd_hdr.src;
    assign m_eth_type     = rd_hdr.etype;

    hdr_fifo_ram #(
        .WIDTH  (WORD_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (accept),
        .wr_addr (wr_ptr[ADDR_W-1:0]),
        .wr_data (wr_word),
        .rd_en   (load),
        .rd_addr (rd_ptr[ADDR_W-1:0]),
        .rd_data (rd_word)
    );

    // Advance the write pointer on accept and the read pointer on output load.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (accept) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (load) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
        end
    end

    // Output valid follows the RAM read register: set on load, cleared once consumed with nothing behind it.
    always_ff @(posedge clk) begin
        if (!rst) begin
            m_eth_hdr_valid <= 1'b0;
        end else if (load) begin
            m_eth_hdr_valid <= 1'b1;
        end else if (m_eth_hdr_ready && empty) begin
            m_eth_hdr_valid <= 1'b0;
        end
    end

    // Report each discarded header with a one-cycle pulse and a saturating tally.
    always_ff @(posedge clk) begin
        if (!rst) begin
            overflow   <= 1'b0;
            drop_count <= '0;
        end else begin
            overflow <= drop;
            if (drop && (drop_count != '1)) begin
                drop_count <= drop_count + CNT_ONE;
            end
        end
    end

endmodule

// File: tb/tb_eth_hdr_fifo_v2.sv
// tb_eth_hdr_fifo_v2: self-checking bench for the Ethernet header FIFO,
// with a backpressure instance and a drop-when-full instance.
module tb_eth_hdr_fifo_v2;

    localparam int DEPTH = 8;
    localparam int UW    = 4;
    localparam int AF    = DEPTH - 2;

    typedef struct packed {
        logic [47:0]   dest;
        logic [47:0]   src;
        logic [15:0]   etype;
        logic [UW-1:0] user;
    } tb_hdr_t;

    logic clk = 1'b0;
    logic rst = 1'b0;

    logic          s_valid, s_ready, m_valid, m_ready, almost_full, overflow;
    logic [47:0]   s_dest, s_src, m_dest, m_src;
    logic [15:0]   s_type, m_type;
    logic [UW-1:0] s_user, m_user;
    logic [3:0]    count;
    logic [15:0]   drop_count;

    logic          d_s_valid, d_s_ready, d_m_valid, d_m_ready, d_almost_full, d_overflow;
    logic [47:0]   d_s_dest, d_s_src, d_m_dest, d_m_src;
    logic [15:0]   d_s_type, d_m_type;
    logic [UW-1:0] d_s_user, d_m_user;
    logic [3:0]    d_count;
    logic [15:0]   d_drop_count;

    int total = 0;
    int bad   = 0;

    eth_hdr_fifo_v2 #(.DEPTH(DEPTH), .USER_WIDTH(UW), .DROP_WHEN_FULL(0)) dut (
        .clk(clk), .rst(rst),
        .s_eth_hdr_valid(s_valid), .s_eth_hdr_ready(s_ready),
        .s_eth_dest_mac(s_dest), .s_eth_src_mac(s_src), .s_eth_type(s_type), .s_eth_hdr_user(s_user),
        .m_eth_hdr_valid(m_valid), .m_eth_hdr_ready(m_ready),
        .m_eth_dest_mac(m_dest), .m_eth_src_mac(m_src), .m_eth_type(m_type), .m_eth_hdr_user(m_user),
        .count(count), .almost_full(almost_full), .overflow(overflow), .drop_count(drop_count)
    );

    eth_hdr_fifo_v2 #(.DEPTH(DEPTH), .USER_WIDTH(UW), .DROP_WHEN_FULL(1)) dut_drop (
        .clk(clk), .rst(rst),
        .s_eth_hdr_valid(d_s_valid), .s_eth_hdr_ready(d_s_ready),
        .s_eth_dest_mac(d_s_dest), .s_eth_src_mac(d_s_src), .s_eth_type(d_s_type), .s_eth_hdr_user(d_s_user),
        .m_eth_hdr_valid(d_m_valid), .m_eth_hdr_ready(d_m_ready),
        .m_eth_dest_mac(d_m_dest), .m_eth_src_mac(d_m_src), .m_eth_type(d_m_type), .m_eth_hdr_user(d_m_user),
        .count(d_count), .almost_full(d_almost_full), .overflow(d_overflow), .drop_count(d_drop_count)
    );

    // Free-running 100 MHz clock.
    always #5 clk = ~clk;

    function automatic tb_hdr_t rand_hdr();
        tb_hdr_t h;
        h.dest  = {16'($urandom), $urandom};
        h.src   = {16'($urandom), $urandom};
        h.etype = 16'($urandom);
        h.user  = UW'($urandom);
        return h;
    endfunction

    function automatic tb_hdr_t got_a();
        return {m_dest, m_src, m_type, m_user};
    endfunction

    function automatic tb_hdr_t got_d();
        return {d_m_dest, d_m_src, d_m_type, d_m_user};
    endfunction

    // Drive the backpressure instance at the falling edge; outputs are sampled 1 ns later.
    task automatic applyStimulus(input logic v, input tb_hdr_t h, input logic mr);
        @(negedge clk);
        s_valid = v;
        {s_dest, s_src, s_type, s_user} = h;
        m_ready = mr;
        #1;
    endtask

    // Same for the drop-mode instance.
    task automatic applyDropStimulus(input logic v, input tb_hdr_t h, input logic mr);
        @(negedge clk);
        d_s_valid = v;
        {d_s_dest, d_s_src, d_s_type, d_s_user} = h;
        d_m_ready = mr;
        #1;
    endtask

    task automatic test_reset();
        s_valid = 0; m_ready = 0; {s_dest, s_src, s_type, s_user} = '0;
        d_s_valid = 0; d_m_ready = 0; {d_s_dest, d_s_src, d_s_type, d_s_user} = '0;
        rst = 0;
        repeat (2) @(posedge clk);
        @(negedge clk); #1;
        total++; if (s_ready !== 1'b0) begin bad++; $display("[TB] FAIL reset_s_ready: got %b want 0", s_ready); end
        total++; if (d_s_ready !== 1'b0) begin bad++; $display("[TB] FAIL reset_d_s_ready: got %b want 0", d_s_ready); end
        total++; if (m_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_m_valid: got %b want 0", m_valid); end
        total++; if (count !== 4'd0) begin bad++; $display("[TB] FAIL reset_count: got %0d want 0", count); end
        total++; if (almost_full !== 1'b0) begin bad++; $display("[TB] FAIL reset_almost_full: got %b want 0", almost_full); end
        total++; if (d_overflow !== 1'b0) begin bad++; $display("[TB] FAIL reset_overflow: got %b want 0", d_overflow); end
        total++; if (d_drop_count !== 16'd0) begin bad++; $display("[TB] FAIL reset_drop_count: got %0d want 0", d_drop_count); end
        total++; if (got_a() !== '0) begin bad++; $display("[TB] FAIL reset_m_data: got %h want 0", got_a()); end
        rst = 1; #1;
        total++; if (s_ready !== 1'b1) begin bad++; $display("[TB] FAIL release_s_ready: got %b want 1", s_ready); end
        total++; if (d_s_ready !== 1'b1) begin bad++; $display("[TB] FAIL release_d_s_ready: got %b want 1", d_s_ready); end
    endtask

    task automatic test_single();
        tb_hdr_t h;
        h = {48'h0A0B0C0D0E0F, 48'h112233445566, 16'h0800, 4'd1};
        applyStimulus(1, h, 1);
        applyStimulus(0, '0, 1);
        total++; if (m_valid !== 1'b0) begin bad++; $display("[TB] FAIL single_early_valid: got %b want 0", m_valid); end
        total++; if (count !== 4'd1) begin bad++; $display("[TB] FAIL single_count1: got %0d want 1", count); end
        applyStimulus(0, '0, 1);
        total++; if (m_valid !== 1'b1) begin bad++; $display("[TB] FAIL single_valid: got %b want 1", m_valid); end
        total++; if (got_a() !== h) begin bad++; $display("[TB] FAIL single_data: got %h want %h", got_a(), h); end
        total++; if (count !== 4'd0) begin bad++; $display("[TB] FAIL single_count0: got %0d want 0", count); end
        applyStimulus(0, '0, 1);
        total++; if (m_valid !== 1'b0) begin bad++; $display("[TB] FAIL single_drained: got %b want 0", m_valid); end
    endtask

    task automatic test_fill();
        tb_hdr_t hs[9];
        int exp_cnt;
        for (int i = 0; i < 9; i++) hs[i] = rand_hdr();
        for (int i = 0; i < 9; i++) begin
            applyStimulus(1, hs[i], 0);
            exp_cnt = (i <= 1) ? i : i - 1;
            total++; if (s_ready !== 1'b1) begin bad++; $display("[TB] FAIL fill_ready[%0d]: got %b want 1", i, s_ready); end
            total++; if (count !== 4'(exp_cnt)) begin bad++; $display("[TB] FAIL fill_count[%0d]: got %0d want %0d", i, count, exp_cnt); end
            total++; if (almost_full !== (exp_cnt >= AF)) begin bad++; $display("[TB] FAIL fill_af[%0d]: got %b want %b", i, almost_full, exp_cnt >= AF); end
        end
        for (int k = 0; k < 2; k++) begin
            applyStimulus(1, rand_hdr(), 0);
            total++; if (s_ready !== 1'b0) begin bad++; $display("[TB] FAIL full_ready: got %b want 0", s_ready); end
            total++; if (count !== 4'd8) begin bad++; $display("[TB] FAIL full_count: got %0d want 8", count); end
            total++; if (almost_full !== 1'b1) begin bad++; $display("[TB] FAIL full_af: got %b want 1", almost_full); end
            total++; if (m_valid !== 1'b1 || got_a() !== hs[0]) begin bad++; $display("[TB] FAIL full_head: got %b/%h want 1/%h", m_valid, got_a(), hs[0]); end
        end
        total++; if (overflow !== 1'b0 || drop_count !== 16'd0) begin bad++; $display("[TB] FAIL nodrop_mode: got %b/%0d want 0/0", overflow, drop_count); end
        for (int k = 0; k < 9; k++) begin
            applyStimulus(0, '0, 1);
            total++; if (m_valid !== 1'b1 || got_a() !== hs[k]) begin bad++; $display("[TB] FAIL fill_drain[%0d]: got %b/%h want 1/%h", k, m_valid, got_a(), hs[k]); end
            total++; if (count !== 4'(8 - k)) begin bad++; $display("[TB] FAIL drain_count[%0d]: got %0d want %0d", k, count, 8 - k); end
        end
        applyStimulus(0, '0, 1);
        total++; if (m_valid !== 1'b0 || count !== 4'd0) begin bad++; $display("[TB] FAIL fill_empty: got %b/%0d want 0/0", m_valid, count); end
    endtask

    task automatic test_streaming();
        tb_hdr_t st[64];
        tb_hdr_t h;
        logic ev;
        for (int i = 0; i < 64; i++) st[i] = rand_hdr();
        for (int j = 0; j <= 66; j++) begin
            if (j < 64) h = st[j]; else h = '0;
            applyStimulus(j < 64, h, 1);
            ev = (j >= 2) && (j <= 65);
            total++; if (s_ready !== 1'b1) begin bad++; $display("[TB] FAIL stream_ready[%0d]: got %b want 1", j, s_ready); end
            total++; if (m_valid !== ev) begin bad++; $display("[TB] FAIL stream_valid[%0d]: got %b want %b", j, m_valid, ev); end
            if (ev) begin
                total++; if (got_a() !== st[j-2]) begin bad++; $display("[TB] FAIL stream_data[%0d]: got %h want %h", j, got_a(), st[j-2]); end
            end
        end
    endtask

    task automatic test_drop();
        tb_hdr_t hs[12];
        logic eo;
        int pulses = 0;
        for (int i = 0; i < 12; i++) hs[i] = rand_hdr();
        for (int j = 0; j < 14; j++) begin
            applyDropStimulus(j < 12, (j < 12) ? hs[j % 12] : '0, 0);
            eo = (j >= 10) && (j <= 12);
            if (d_overflow === 1'b1) pulses++;
            total++; if (d_s_ready !== 1'b1) begin bad++; $display("[TB] FAIL drop_ready[%0d]: got %b want 1", j, d_s_ready); end
            total++; if (d_overflow !== eo) begin bad++; $display("[TB] FAIL drop_overflow[%0d]: got %b want %b", j, d_overflow, eo); end
        end
        total++; if (pulses != 3) begin bad++; $display("[TB] FAIL drop_pulses: got %0d want 3", pulses); end
        total++; if (d_drop_count !== 16'd3) begin bad++; $display("[TB] FAIL drop_count: got %0d want 3", d_drop_count); end
        total++; if (d_count !== 4'd8 || d_almost_full !== 1'b1) begin bad++; $display("[TB] FAIL drop_level: got %0d/%b want 8/1", d_count, d_almost_full); end
        for (int k = 0; k < 9; k++) begin
            applyDropStimulus(0, '0, 1);
            total++; if (d_m_valid !== 1'b1 || got_d() !== hs[k]) begin bad++; $display("[TB] FAIL drop_drain[%0d]: got %b/%h want 1/%h", k, d_m_valid, got_d(), hs[k]); end
        end
        applyDropStimulus(0, '0, 1);
        total++; if (d_m_valid !== 1'b0) begin bad++; $display("[TB] FAIL drop_empty: got %b want 0", d_m_valid); end
        total++; if (d_drop_count !== 16'd3 || d_overflow !== 1'b0) begin bad++; $display("[TB] FAIL drop_after: got %0d/%b want 3/0", d_drop_count, d_overflow); end
    endtask

    task automatic test_random();
        tb_hdr_t sb[$];
        tb_hdr_t h, prev_data;
        logic v, mr, prev_hold, er;
        int sent = 0;
        int cycles = 0;
        int exp_cnt;
        prev_hold = 0;
        prev_data = '0;
        while ((sent < 1000 || sb.size() != 0) && cycles < 20000) begin
            v  = (sent < 1000) && ($urandom_range(0, 3) != 0);
            mr = 1'($urandom_range(0, 1));
            h  = rand_hdr();
            applyStimulus(v, h, mr);
            er = (sb.size() < DEPTH + 1);
            total++; if (s_ready !== er) begin bad++; $display("[TB] FAIL rand_ready[%0d]: got %b want %b", cycles, s_ready, er); end
            if (prev_hold) begin
                total++; if (m_valid !== 1'b1 || got_a() !== prev_data) begin bad++; $display("[TB] FAIL rand_hold[%0d]: got %b/%h want 1/%h", cycles, m_valid, got_a(), prev_data); end
            end
            if (m_valid === 1'b1) begin
                total++;
                if (sb.size() == 0) begin bad++; $display("[TB] FAIL rand_spurious[%0d]: got valid want idle", cycles); end
                else if (got_a() !== sb[0]) begin bad++; $display("[TB] FAIL rand_data[%0d]: got %h want %h", cycles, got_a(), sb[0]); end
                exp_cnt = sb.size() - 1;
            end else begin
                exp_cnt = sb.size();
            end
            if (exp_cnt < 0) exp_cnt = 0;
            total++; if (count !== 4'(exp_cnt)) begin bad++; $display("[TB] FAIL rand_count[%0d]: got %0d want %0d", cycles, count, exp_cnt); end
            prev_hold = (m_valid === 1'b1) && !mr;
            prev_data = got_a();
            if (m_valid === 1'b1 && mr && sb.size() != 0) void'(sb.pop_front());
            if (v && s_ready === 1'b1) begin
                sb.push_back(h);
                sent++;
            end
            cycles++;
        end
        total++; if (cycles >= 20000) begin bad++; $display("[TB] FAIL rand_timeout: got %0d cycles with %0d pending want drained", cycles, sb.size()); end
    endtask

    task automatic test_midreset();
        tb_hdr_t h;
        for (int i = 0; i < 5; i++) applyStimulus(1, rand_hdr(), 0);
        applyStimulus(0, '0, 0);
        rst = 0;
        applyStimulus(0, '0, 0);
        rst = 1; #1;
        total++; if (m_valid !== 1'b0) begin bad++; $display("[TB] FAIL midrst_valid: got %b want 0", m_valid); end
        total++; if (count !== 4'd0) begin bad++; $display("[TB] FAIL midrst_count: got %0d want 0", count); end
        total++; if (drop_count !== 16'd0 || d_drop_count !== 16'd0) begin bad++; $display("[TB] FAIL midrst_drop_count: got %0d/%0d want 0/0", drop_count, d_drop_count); end
        total++; if (s_ready !== 1'b1) begin bad++; $display("[TB] FAIL midrst_ready: got %b want 1", s_ready); end
        for (int k = 0; k < 3; k++) begin
            applyStimulus(0, '0, 1);
            total++; if (m_valid !== 1'b0) begin bad++; $display("[TB] FAIL midrst_stale[%0d]: got %b want 0", k, m_valid); end
        end
        h = rand_hdr();
        applyStimulus(1, h, 1);
        applyStimulus(0, '0, 1);
        total++; if (m_valid !== 1'b0) begin bad++; $display("[TB] FAIL midrst_early: got %b want 0", m_valid); end
        applyStimulus(0, '0, 1);
        total++; if (m_valid !== 1'b1 || got_a() !== h) begin bad++; $display("[TB] FAIL midrst_hdr: got %b/%h want 1/%h", m_valid, got_a(), h); end
        for (int k = 0; k < 2; k++) begin
            applyStimulus(0, '0, 1);
            total++; if (m_valid !== 1'b0 || count !== 4'd0) begin bad++; $display("[TB] FAIL midrst_alone[%0d]: got %b/%0d want 0/0", k, m_valid, count); end
        end
    endtask

    // Run every scenario in order, then report.
    initial begin
        test_reset();
        test_single();
        test_fill();
        test_streaming();
        test_drop();
        test_random();
        test_midreset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Guard against a stalled run.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got timeout want completion (total=%0d bad=%0d)", total, bad);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
